hex_tx_fmt: RTL

Upstream feeder for the UART transmit controller. Accepts a binary word and emits its uppercase ASCII hex representation, MSB nibble first, optionally followed by CR LF. Output is a byte stream on dout/dout_rdy for the controller's din/din_rdy. Emission is paced by a sink-ready input and a fixed inter-byte gap, so no byte is offered while the sink cannot take it.

---
 rtl/uart_pkg.sv | 30 +++
 rtl/nib2ascii_mux.sv | 35 +++
 rtl/hex_tx_fmt.sv | 100 ++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared constants, state encoding and ASCII helper for the UART transmit path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package uart_pkg;

  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;
  localparam logic [7:0] ASCII_0  = 8'h30;
  localparam logic [7:0] ASCII_A  = 8'h41;

  // Byte index covers up to 16 digits plus CR LF (18 bytes).
  localparam int IDX_W = 5;
  // Gap counter holds GAP values up to 255.
  localparam int GAP_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    WAIT = 2'd2
  } state_t;

  // Uppercase hex digit for one nibble.
  function automatic logic [7:0] nib2ascii(input logic [3:0] nib);
    if (nib < 4'd10) begin
      return ASCII_0 + {4'd0, nib};
    end
    return ASCII_A + {4'd0, nib - 4'd10};
  endfunction

endpackage

// File: rtl/nib2ascii_mux.sv
// Selects byte idx of the formatted word: hex digits MSB first, then CR, LF.
// Latency: combinational.
// Backpressure: none; pure function of word and idx.
// Ports: word - latched word; idx - byte index; char - ASCII byte for idx.
module nib2ascii_mux
  import uart_pkg::*;
#(
  parameter int NIBBLES = 8
) (
  input  logic [4*NIBBLES-1:0] word,
  input  logic [IDX_W-1:0]     idx,
  output logic [7:0]           char
);

  logic [3:0] nib;

  always_comb begin
    nib = 4'd0;
    // Index 0 is the most significant nibble.
    for (int n = 0; n < NIBBLES; n++) begin
      if (idx == IDX_W'(n)) begin
        nib = word[4*(NIBBLES-n)-1 -: 4];
      end
    end

    if (idx < IDX_W'(NIBBLES)) begin
      char = nib2ascii(nib);
    end else if (idx == IDX_W'(NIBBLES)) begin
      char = ASCII_CR;
    end else begin
      char = ASCII_LF;
    end
  end

endmodule

// File: rtl/hex_tx_fmt.sv
// Formats a binary word as uppercase ASCII hex (MSB first, optional CR LF) into a byte stream.
// Latency: first byte one clock after acceptance; one byte every GAP+1 clocks while sink_rdy is high.
// Backpressure: sink_rdy is sampled only when a byte is ready to go; low stalls, words arriving while busy are dropped.
// Ports: clk/rst (async active-low); word_in/word_vld request; sink_rdy downstream ready;
//        dout/dout_rdy byte strobe; busy while emitting; done after last gap; drop on rejected request.
module hex_tx_fmt
  import uart_pkg::*;
#(
  parameter int NIBBLES = 8,
  parameter int CRLF    = 1,
  parameter int GAP     = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [4*NIBBLES-1:0] word_in,
  input  logic                 word_vld,
  input  logic                 sink_rdy,
  output logic [7:0]           dout,
  output logic                 dout_rdy,
  output logic                 busy,
  output logic                 done,
  output logic                 drop
);

  localparam int                L        = NIBBLES + 2*CRLF;
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(L-1);
  localparam logic [GAP_W-1:0]  GAP_LD   = GAP_W'(GAP);

  state_t               state;
  logic [IDX_W-1:0]     idx;
  logic [GAP_W-1:0]     gap_cnt;
  logic [4*NIBBLES-1:0] word_q;
  logic [7:0]           char;

  nib2ascii_mux #(
    .NIBBLES(NIBBLES)
  ) u_mux (
    .word(word_q),
    .idx (idx),
    .char(char)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      idx      <= '0;
      gap_cnt  <= '0;
      word_q   <= '0;
      dout     <= 8'h00;
      dout_rdy <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      drop     <= 1'b0;
    end else begin
      dout_rdy <= 1'b0;
      done     <= 1'b0;
      // busy is still high on the edge it falls, so a request there is dropped too.
      drop     <= word_vld && busy;

      case (state)
        IDLE: begin
          if (word_vld) begin
            word_q <= word_in;
            idx    <= '0;
            busy   <= 1'b1;
            state  <= SEND;
          end
        end

        SEND: begin
          if (sink_rdy) begin
            dout     <= char;
            dout_rdy <= 1'b1;
            gap_cnt  <= GAP_LD;
            state    <= WAIT;
          end
        end

        WAIT: begin
          gap_cnt <= gap_cnt - GAP_W'(1);
          // Exit on the edge the count reaches zero: GAP clocks in WAIT per byte.
          if (gap_cnt <= GAP_W'(1)) begin
            gap_cnt <= '0;
            if (idx == LAST_IDX) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= IDLE;
            end else begin
              idx   <= idx + IDX_W'(1);
              state <= SEND;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
